// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory (dmem_lsu).
// Provides the funct3 access-size encoding, the fault codes, the sequencer
// states and the request-legality checks used by the top level.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = WORD_W / 8;

    // Access size, RV32 funct3 encoding
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } size_e;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        MISALIGN = 2'b01,
        RANGE    = 2'b10,
        ILLEGAL  = 2'b11
    } fault_e;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Unused funct3 codes, or an unsigned size on a store
    function automatic logic size_illegal(input logic [2:0] size, input logic is_store);
        return (size == 3'b011) || (size[2:1] == 2'b11) || (is_store && size[2]);
    endfunction

    // Halfwords need even addresses, words need 4-byte alignment
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lo);
        return ((size[1:0] == 2'b01) && lo[0]) ||
               ((size[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for sub-word accesses.
// Ports:
//   size     - funct3 access size
//   addr_lo  - byte offset within the word (A[1:0])
//   wd       - right-aligned store data
//   rword    - raw RAM word being loaded
//   be_c     - per-lane write enable for the store
//   wdata_c  - store data replicated onto the addressed lanes
//   rdata_c  - load result, extracted and sign/zero extended
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] wd,
    input  logic [WORD_W-1:0] rword,
    output logic [LANES-1:0]  be_c,
    output logic [WORD_W-1:0] wdata_c,
    output logic [WORD_W-1:0] rdata_c
);

    logic [WORD_W-1:0] shifted;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    // Store path: replicate the datum so every candidate lane carries it
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wd;
        case (size[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr_lo;
                wdata_c = {4{wd[7:0]}};
            end
            2'b01: begin
                be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wd[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = wd;
            end
        endcase
    end

    // Load path: shift the addressed lane down, then extend
    always_comb begin
        shifted  = rword >> {addr_lo, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
        rdata_c  = rword;
        case (size)
            LB:      rdata_c = {{24{byte_sel[7]}}, byte_sel};
            LBU:     rdata_c = {24'h0, byte_sel};
            LH:      rdata_c = {{16{half_sel[15]}}, half_sel};
            LHU:     rdata_c = {16'h0, half_sel};
            default: rdata_c = rword;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressed data RAM with RV32 sub-word load/store for the MEM stage.
// After reset an init sequencer clears every word (BUSY high), then requests
// are accepted every cycle with a one-cycle registered load result.
// Ports:
//   CLK, RST_N    - clock, synchronous active-low reset
//   RE, WE        - load / store request (both may be high: read-first)
//   SIZE          - funct3 access size
//   A, WD         - byte address, right-aligned store data
//   RD, RD_VALID  - registered load result and its one-cycle strobe
//   BUSY          - high while the RAM is being cleared
//   FAULT         - one-cycle pulse on a rejected request
//   FAULT_CODE    - code of the most recent rejection (sticky)
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RE,
    input  logic              WE,
    input  logic [2:0]        SIZE,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] RD,
    output logic              RD_VALID,
    output logic              BUSY,
    output logic              FAULT,
    output logic [1:0]        FAULT_CODE
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              rd_valid_q, rd_valid_d;
    logic              fault_q, fault_d;
    fault_e            fcode_q, fcode_d;
    logic              busy_q, busy_d;

    logic              clr_c;
    logic              wr_c;
    logic              req_c;
    fault_e            chk_c;
    logic [IDX_W-1:0]  widx_c;
    logic [ADDR_W-1:0] a_hi_c;
    logic [LANES-1:0]  be_c;
    logic [WORD_W-1:0] wdata_c;
    logic [WORD_W-1:0] rdata_c;

    assign widx_c = A[IDX_W+1:2];
    assign a_hi_c = A >> (IDX_W + 2);
    assign req_c  = RE | WE;

    dmem_lane_align u_align (
        .size    (SIZE),
        .addr_lo (A[1:0]),
        .wd      (WORD_W'(WD)),
        .rword   (mem[widx_c]),
        .be_c    (be_c),
        .wdata_c (wdata_c),
        .rdata_c (rdata_c)
    );

    // Request checks in priority order: size, alignment, range
    always_comb begin
        chk_c = NONE;
        if (size_illegal(SIZE, WE)) begin
            chk_c = ILLEGAL;
        end else if (misaligned(SIZE, A[1:0])) begin
            chk_c = MISALIGN;
        end else if (a_hi_c != '0) begin
            chk_c = RANGE;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_d       = rd_q;
        rd_valid_d = 1'b0;
        fault_d    = 1'b0;
        fcode_d    = fcode_q;
        busy_d     = busy_q;
        clr_c      = 1'b0;
        wr_c       = 1'b0;
        case (state_q)
            INIT: begin
                clr_c = 1'b1;
                ptr_d = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end
            end
            READY: begin
                busy_d = 1'b0;
                if (req_c) begin
                    if (chk_c != NONE) begin
                        fault_d = 1'b1;
                        fcode_d = chk_c;
                    end else begin
                        wr_c = WE;
                        if (RE) begin
                            rd_d       = DATA_W'(rdata_c);
                            rd_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= INIT;
            ptr_q      <= '0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            fcode_q    <= NONE;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            fault_q    <= fault_d;
            fcode_q    <= fcode_d;
            busy_q     <= busy_d;
        end
    end

    // RAM write port; reset gates it so a held reset never disturbs contents
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            if (clr_c) begin
                mem[ptr_q] <= '0;
            end else if (wr_c) begin
                for (int i = 0; i < int'(LANES); i++) begin
                    if (be_c[i]) begin
                        mem[widx_c][8*i +: 8] <= wdata_c[8*i +: 8];
                    end
                end
            end
        end
    end

    assign RD         = rd_q;
    assign RD_VALID   = rd_valid_q;
    assign BUSY       = busy_q;
    assign FAULT      = fault_q;
    assign FAULT_CODE = fcode_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed scenarios plus randomized
// traffic compared against a byte-array reference model.
module tb_dmem_lsu;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        re;
    logic        we;
    logic [2:0]  size;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        rd_valid;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mbyte [BYTES];
    logic [31:0] rd_exp;
    logic [1:0]  fc_exp;

    always #5 clk = ~clk;

    dmem_lsu #(
        .DATA_W (32),
        .ADDR_W (32),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .RE         (re),
        .WE         (we),
        .SIZE       (size),
        .A          (a),
        .WD         (wd),
        .RD         (rd),
        .RD_VALID   (rd_valid),
        .BUSY       (busy),
        .FAULT      (fault),
        .FAULT_CODE (fault_code)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(BYTES); i++) mbyte[i] = 8'h00;
        rd_exp = 32'h0;
        fc_exp = 2'b00;
    endtask

    // Drive one request at a negedge, check the response at the next negedge
    task automatic op(input logic r, input logic w, input logic [2:0] sz,
                      input logic [31:0] addr, input logic [31:0] data);
        logic [1:0]  code;
        logic        v_exp;
        logic        f_exp;
        logic [31:0] val;
        int          n;
        re = r; we = w; size = sz; a = addr; wd = data;
        code = 2'b00;
        if (sz == 3'd3 || sz == 3'd6 || sz == 3'd7 || (w && sz[2]))
            code = 2'b11;
        else if ((sz[1:0] == 2'd1 && addr[0]) || (sz[1:0] == 2'd2 && addr[1:0] != 2'd0))
            code = 2'b01;
        else if (addr >= BYTES)
            code = 2'b10;
        v_exp = 1'b0;
        f_exp = 1'b0;
        if ((r || w) && code != 2'b00) begin
            f_exp  = 1'b1;
            fc_exp = code;
        end else if (r || w) begin
            n = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
            if (r) begin
                val = 32'h0;
                for (int i = 0; i < n; i++) val |= 32'(mbyte[int'(addr) + i]) << (8 * i);
                if (!sz[2] && n == 1) val = {{24{val[7]}}, val[7:0]};
                if (!sz[2] && n == 2) val = {{16{val[15]}}, val[15:0]};
                rd_exp = val;
                v_exp  = 1'b1;
            end
            if (w) begin
                for (int i = 0; i < n; i++) mbyte[int'(addr) + i] = data[8*i +: 8];
            end
        end
        @(negedge clk);
        chk("rd_valid", 32'(rd_valid), 32'(v_exp));
        chk("fault", 32'(fault), 32'(f_exp));
        chk("fault_code", 32'(fault_code), 32'(fc_exp));
        chk("rd", rd, rd_exp);
    endtask

    task automatic idle();
        re = 1'b0; we = 1'b0; size = 3'd0; a = 32'h0; wd = 32'h0;
    endtask

    // Count negedges with BUSY high; bounded so a stuck BUSY cannot hang the run
    task automatic count_busy(output int n, output logic saw_valid);
        n = 0;
        saw_valid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (rd_valid || fault) saw_valid = 1'b1;
            if (!busy) break;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          nb;
        logic        sv;
        logic        r, w;
        logic [2:0]  sz;
        logic [31:0] addr;

        rst_n = 1'b0;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rd", rd, 32'h0);
        chk("reset_rd_valid", 32'(rd_valid), 32'h0);
        chk("reset_fault", 32'(fault), 32'h0);
        chk("reset_fault_code", 32'(fault_code), 32'h0);
        chk("reset_busy", 32'(busy), 32'h1);

        // Release reset with a load pending during BUSY
        rst_n = 1'b1;
        re = 1'b1; size = 3'b010; a = 32'h10;
        count_busy(nb, sv);
        chk("busy_cycles", 32'(nb), 32'(DEPTH));
        chk("busy_no_response", 32'(sv), 32'h0);
        idle();

        for (int i = 0; i < int'(DEPTH); i++) op(1'b1, 1'b0, 3'b010, 32'(i * 4), 32'h0);

        // Word round-trip
        for (int i = 0; i < int'(DEPTH); i++) op(1'b0, 1'b1, 3'b010, 32'(i * 4), 32'(i * 4));
        for (int i = 0; i < int'(DEPTH); i++) op(1'b1, 1'b0, 3'b010, 32'(i * 4), 32'h0);

        // Sub-word
        op(1'b0, 1'b1, 3'b010, 32'h40, 32'h11223344);
        op(1'b0, 1'b1, 3'b000, 32'h41, 32'h000000AB);
        op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        chk("sub_lw", rd, 32'h1122AB44);
        op(1'b1, 1'b0, 3'b000, 32'h41, 32'h0);
        chk("sub_lb", rd, 32'hFFFFFFAB);
        op(1'b1, 1'b0, 3'b100, 32'h41, 32'h0);
        chk("sub_lbu", rd, 32'h000000AB);
        op(1'b1, 1'b0, 3'b001, 32'h42, 32'h0);
        chk("sub_lh", rd, 32'h00001122);

        // Faults
        op(1'b1, 1'b0, 3'b010, 32'h02, 32'h0);
        chk("flt_lw_mis", 32'(fault_code), 32'h1);
        op(1'b0, 1'b1, 3'b001, 32'h03, 32'hFFFF);
        chk("flt_sh_mis", 32'(fault_code), 32'h1);
        op(1'b1, 1'b0, 3'b010, 32'h00, 32'h0);
        chk("flt_ram_kept", rd, 32'h0);
        op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        chk("flt_range", 32'(fault_code), 32'h2);
        op(1'b1, 1'b0, 3'b011, 32'h00, 32'h0);
        chk("flt_size011", 32'(fault_code), 32'h3);
        op(1'b0, 1'b1, 3'b100, 32'h00, 32'h55);
        chk("flt_sb_unsigned", 32'(fault_code), 32'h3);

        // Read-first
        op(1'b0, 1'b1, 3'b010, 32'h20, 32'h5);
        op(1'b1, 1'b1, 3'b010, 32'h20, 32'h9);
        chk("read_first_old", rd, 32'h5);
        op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        chk("read_first_new", rd, 32'h9);

        // Randomized traffic, back-to-back
        for (int k = 0; k < 400; k++) begin
            r    = 1'($urandom_range(0, 1));
            w    = 1'($urandom_range(0, 1));
            sz   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 271));
            op(r, w, sz, addr, $urandom);
        end

        // Mid-operation reset
        op(1'b0, 1'b1, 3'b010, 32'h08, 32'hDEADBEEF);
        op(1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
        op(1'b1, 1'b0, 3'b010, 32'h04, 32'h0);
        rst_n = 1'b0;
        re = 1'b1; we = 1'b0; size = 3'b010; a = 32'h08;
        @(negedge clk);
        chk("midrst_rd_valid", 32'(rd_valid), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h1);
        chk("midrst_rd", rd, 32'h0);
        rst_n = 1'b1;
        count_busy(nb, sv);
        chk("midrst_busy_cycles", 32'(nb), 32'(DEPTH));
        model_clear();
        op(1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
        chk("midrst_cleared", rd, 32'h0);
        idle();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised successor to the pipeline's word-only data memory.
- Byte-addressed data RAM with RV32 sub-word load/store (byte/half/word) and sign or zero extension on loads.
- Registered read with a valid strobe, fault reporting for misaligned, out-of-range and illegal-size accesses.
- Self-clearing init sequencer after reset. Sits in the MEM stage of cpu_pipelined.

Parameters:
- DATA_W, 32: data width in bits; must equal 32 (4 byte lanes).
- ADDR_W, 32: byte-address width.
- DEPTH, 64: number of 32-bit words; power of two, ≥ 2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- RE  in  1  load request.
- WE  in  1  store request.
- SIZE  in  3  access size, funct3 encoding.
- A  in  ADDR_W  byte address.
- WD  in  DATA_W  store data, right-aligned.
- RD  out  DATA_W  load result, registered, extended.
- RD_VALID  out  1  one-cycle pulse when RD carries a new load result.
- BUSY  out  1  high while the init sequencer clears the RAM.
- FAULT  out  1  one-cycle pulse on a rejected access.
- FAULT_CODE  out  2  01 misaligned, 10 out-of-range, 11 illegal size; holds its last value.

Behaviour:
- **Reset.** RST_N low at a posedge sets:
  - state = INIT, init pointer = 0;
  - RD = 0, RD_VALID = 0, FAULT = 0, FAULT_CODE = 00, BUSY = 1.
  - Reset asserted mid-operation (including mid-INIT) restarts the clear from word 0.
- **INIT state.**
  - Each cycle with RST_N high: write 0 to word[ptr], then ptr++.
  - After writing word DEPTH-1: state = READY, BUSY = 0 on the following cycle.
  - BUSY is therefore high for exactly DEPTH cycles after reset release.
  - RE/WE during INIT are ignored: no RAM change, no RD_VALID, no FAULT.
- **Request decode (READY).** A request exists when RE or WE is 1. Checks in priority order:
  - SIZE ∈ {011, 110, 111}, or a store with SIZE[2] = 1 → illegal size, code 11.
  - Half with A[0] = 1, or word with A[1:0] ≠ 00 → misaligned, code 01.
  - A ≥ DEPTH*4 → out-of-range, code 10.
  - Any rejected request: FAULT = 1 next cycle, FAULT_CODE updated, no RAM write, RD_VALID = 0, RD unchanged.
- **Store (WE = 1, legal).** Word index = A[log2(DEPTH)+1:2]; updated at the posedge.
  - SB: lane A[1:0] ← WD[7:0].
  - SH: lanes A[1]*2 and +1 ← WD[15:0].
  - SW: all four lanes ← WD.
  - All other lanes are preserved.
- **Load (RE = 1, legal).**
  - RD and RD_VALID update at the next posedge, so latency is 1 cycle.
  - Lane extraction is selected by A[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- **RE and WE both 1.**
  - Both checks use the same SIZE/A; a fault rejects both.
  - If legal, the store is performed and the load returns the pre-write contents (read-first).
- **Idle cycle** (no request, or rejected): RD holds its previous value; RD_VALID = 0.
- **Back-to-back access.** A store at cycle n followed by a load of the same address at n+1 returns the new data.
- **Pipelining.** A request is accepted every cycle; there is no back-pressure other than BUSY.
- **Address wrap.** Upper address bits are never silently wrapped; any address beyond the array is an out-of-range fault.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum for SIZE: LB=000, LH=001, LW=010, LBU=100, LHU=101;
  - typedef enum for FAULT_CODE: NONE=00, MISALIGN=01, RANGE=10, ILLEGAL=11;
  - typedef enum for state: INIT, READY.
- One combinational sub-module, dmem_lane_align:
  - store path: WD + SIZE + A[1:0] → 4-bit byte-enable and lane-shifted write data;
  - load path: word + SIZE + A[1:0] → extended result.
- The top level holds the RAM array, init sequencer, request checks and output registers.

Test Plan:
- Reset/init: hold RST_N low 2 cycles, release → BUSY high for exactly 64 cycles; a LW to 0x10 issued during BUSY gives no RD_VALID; LW of every word after BUSY falls → 0x00000000.
- Word round-trip: SW A = 0..252 step 4, WD = A; then LW same addresses → RD = A one cycle after each request, RD_VALID = 1.
- Sub-word: SW 0x40 = 0x11223344; SB 0x41 = 0xAB → LW 0x40 = 0x1122AB44; LB 0x41 = 0xFFFFFFAB; LBU 0x41 = 0x000000AB; LH 0x42 = 0x00001122.
- Faults:
  - LW 0x02 → FAULT = 1, code 01, no RD_VALID;
  - SH 0x03 → code 01, RAM unchanged;
  - LW 0x100 → code 10;
  - SIZE = 011 → code 11;
  - SB with SIZE = 100 → code 11.
- Read-first: word 0x20 = 0x5; RE = WE = 1, SW 0x20 = 0x9 → RD = 0x5; next-cycle LW 0x20 → RD = 0x9.
- Mid-op reset: write 0xDEADBEEF to 0x08, pulse RST_N low 1 cycle during a load stream → RD_VALID = 0, BUSY = 1, then after 64 cycles LW 0x08 → 0x00000000.
